// File: rtl/axis_wormhole_arbiter.sv
// N-input to 1-output AXI-Stream wormhole arbiter for a NoC router output port.
// A granted input holds the output until its TLAST beat; per-input packet and stall PMU counters.
//
// state  | meaning
// IDLE   | no packet in flight; grant recomputed each cycle from in_tvalid
// LOCKED | packet in flight; only grant_q is served until its TLAST beat is accepted
module axis_wormhole_arbiter #(
    parameter int N_PORTS    = 5,
    parameter int DATA_WIDTH = 40,
    parameter int ARB_MODE   = 0,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [N_PORTS-1:0]              in_tvalid,
    output logic [N_PORTS-1:0]              in_tready,
    input  logic [N_PORTS*DATA_WIDTH-1:0]   in_tdata,
    input  logic [N_PORTS-1:0]              in_tlast,
    output logic                            out_tvalid,
    input  logic                            out_tready,
    output logic [DATA_WIDTH-1:0]           out_tdata,
    output logic                            out_tlast,
    input  logic                            cnt_clear,
    output logic [N_PORTS*CNT_WIDTH-1:0]    pkt_count,
    output logic [CNT_WIDTH-1:0]            stall_count
);

    localparam int GW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam logic [GW-1:0] LAST_IDX = GW'(N_PORTS - 1);

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    state_t                  state_q, state_d;
    logic [GW-1:0]           grant_q, grant_d;
    logic [GW-1:0]           rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]           arb_grant;
    logic [GW-1:0]           grant;
    logic                    can_load;
    logic                    sel_valid;
    logic                    sel_last;
    logic [DATA_WIDTH-1:0]   sel_data;
    logic                    accept;

    logic                    out_tvalid_q, out_tvalid_d;
    logic [DATA_WIDTH-1:0]   out_tdata_q, out_tdata_d;
    logic                    out_tlast_q, out_tlast_d;
    logic [CNT_WIDTH-1:0]    pkt_cnt_q [N_PORTS];
    logic [CNT_WIDTH-1:0]    pkt_cnt_d [N_PORTS];
    logic [CNT_WIDTH-1:0]    stall_cnt_q, stall_cnt_d;

    // Round-robin walks forward from the input after the last packet winner.
    always_comb begin
        logic [GW-1:0] idx;
        logic          found;
        idx       = rr_ptr_q;
        found     = 1'b0;
        arb_grant = '0;
        if (ARB_MODE == 0) begin
            for (int k = 0; k < N_PORTS; k++) begin
                idx = (idx == LAST_IDX) ? '0 : idx + 1'b1;
                if (!found && in_tvalid[idx]) begin
                    found     = 1'b1;
                    arb_grant = idx;
                end
            end
        end else begin
            for (int i = N_PORTS - 1; i >= 0; i--) begin
                if (in_tvalid[i]) begin
                    arb_grant = GW'(i);
                end
            end
        end
    end

    assign grant    = (state_q == LOCKED) ? grant_q : arb_grant;
    assign can_load = !out_tvalid_q || out_tready;

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (grant == GW'(i)) begin
                sel_valid = in_tvalid[i];
                sel_last  = in_tlast[i];
                sel_data  = in_tdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign accept = can_load && sel_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= LAST_IDX;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (sel_last) begin
                        rr_ptr_d = grant;
                    end else begin
                        state_d = LOCKED;
                        grant_d = grant;
                    end
                end
            end
            LOCKED: begin
                if (accept && sel_last) begin
                    state_d  = IDLE;
                    rr_ptr_d = grant_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_tready = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            in_tready[i] = rst_n && can_load && (grant == GW'(i));
        end
    end

    // Output stage and PMU counters; cnt_clear beats any same-cycle increment.
    always_comb begin
        out_tvalid_d = out_tvalid_q;
        out_tdata_d  = out_tdata_q;
        out_tlast_d  = out_tlast_q;
        if (accept) begin
            out_tvalid_d = 1'b1;
            out_tdata_d  = sel_data;
            out_tlast_d  = sel_last;
        end else if (out_tready) begin
            out_tvalid_d = 1'b0;
        end

        stall_cnt_d = stall_cnt_q;
        if (cnt_clear) begin
            stall_cnt_d = '0;
        end else if (out_tvalid_q && !out_tready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end

        for (int i = 0; i < N_PORTS; i++) begin
            pkt_cnt_d[i] = pkt_cnt_q[i];
            if (cnt_clear) begin
                pkt_cnt_d[i] = '0;
            end else if (accept && sel_last && (grant == GW'(i)) && (pkt_cnt_q[i] != '1)) begin
                pkt_cnt_d[i] = pkt_cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_tvalid_q <= 1'b0;
            out_tdata_q  <= '0;
            out_tlast_q  <= 1'b0;
            stall_cnt_q  <= '0;
            for (int i = 0; i < N_PORTS; i++) begin
                pkt_cnt_q[i] <= '0;
            end
        end else begin
            out_tvalid_q <= out_tvalid_d;
            out_tdata_q  <= out_tdata_d;
            out_tlast_q  <= out_tlast_d;
            stall_cnt_q  <= stall_cnt_d;
            for (int i = 0; i < N_PORTS; i++) begin
                pkt_cnt_q[i] <= pkt_cnt_d[i];
            end
        end
    end

    assign out_tvalid  = out_tvalid_q;
    assign out_tdata   = out_tdata_q;
    assign out_tlast   = out_tlast_q;
    assign stall_count = stall_cnt_q;

    for (genvar g = 0; g < N_PORTS; g++) begin : g_pkt
        assign pkt_count[g*CNT_WIDTH +: CNT_WIDTH] = pkt_cnt_q[g];
    end

endmodule

// File: tb/tb_axis_wormhole_arbiter.sv
// Bench for axis_wormhole_arbiter: a round-robin instance and a fixed-priority instance with
// 2-bit counters share the input stimulus; sel picks the instance the driver and scoreboard follow.
module tb_axis_wormhole_arbiter;
    localparam int NP  = 5;
    localparam int DW  = 40;
    localparam int CW0 = 16;
    localparam int CW1 = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NP-1:0]     in_tvalid, in_tlast;
    logic [NP*DW-1:0]  in_tdata;
    logic              out_tready = 1'b1;
    logic              cnt_clear = 1'b0;
    logic [NP-1:0]     tready0, tready1;
    logic              v0, v1, l0, l1;
    logic [DW-1:0]     d0, d1;
    logic [NP*CW0-1:0] pc0;
    logic [NP*CW1-1:0] pc1;
    logic [CW0-1:0]    st0;
    logic [CW1-1:0]    st1;

    axis_wormhole_arbiter #(.N_PORTS(NP), .DATA_WIDTH(DW), .ARB_MODE(0), .CNT_WIDTH(CW0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_tvalid(in_tvalid), .in_tready(tready0), .in_tdata(in_tdata),
        .in_tlast(in_tlast), .out_tvalid(v0), .out_tready(out_tready), .out_tdata(d0), .out_tlast(l0),
        .cnt_clear(cnt_clear), .pkt_count(pc0), .stall_count(st0));

    axis_wormhole_arbiter #(.N_PORTS(NP), .DATA_WIDTH(DW), .ARB_MODE(1), .CNT_WIDTH(CW1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_tvalid(in_tvalid), .in_tready(tready1), .in_tdata(in_tdata),
        .in_tlast(in_tlast), .out_tvalid(v1), .out_tready(out_tready), .out_tdata(d1), .out_tlast(l1),
        .cnt_clear(cnt_clear), .pkt_count(pc1), .stall_count(st1));

    logic          sel = 1'b0;
    logic [NP-1:0] tready_s;
    logic          o_v, o_l;
    logic [DW-1:0] o_d;
    assign tready_s = sel ? tready1 : tready0;
    assign o_v      = sel ? v1 : v0;
    assign o_l      = sel ? l1 : l0;
    assign o_d      = sel ? d1 : d0;

    int checks = 0;
    int failures = 0;
    int n_pops = 0;
    int acc_cnt [NP];
    logic [NP-1:0] acc_m = '0;
    logic [DW:0]   port_q [NP][$];
    logic [DW:0]   sb_q [$];

    function automatic logic [DW-1:0] mk(input int p, input int k, input int b);
        mk = {p[7:0], k[15:0], b[15:0]};
    endfunction

    task automatic src_pkt(input int p, input int k, input int n);
        for (int b = 0; b < n; b++) port_q[p].push_back({(b == n - 1), mk(p, k, b)});
    endtask

    task automatic exp_pkt(input int p, input int k, input int n);
        for (int b = 0; b < n; b++) sb_q.push_back({(b == n - 1), mk(p, k, b)});
    endtask

    // Source driver: presents queue heads just after each rising edge.
    initial begin
        in_tvalid = '0;
        in_tlast  = '0;
        in_tdata  = '0;
        for (int i = 0; i < NP; i++) acc_cnt[i] = 0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NP; i++) begin
                if (acc_m[i] && port_q[i].size() > 0) begin
                    void'(port_q[i].pop_front());
                    acc_cnt[i]++;
                end
                if (port_q[i].size() > 0) begin
                    in_tvalid[i]           = 1'b1;
                    in_tdata[i*DW +: DW]   = port_q[i][0][DW-1:0];
                    in_tlast[i]            = port_q[i][0][DW];
                end else begin
                    in_tvalid[i]           = 1'b0;
                    in_tdata[i*DW +: DW]   = '0;
                    in_tlast[i]            = 1'b0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            acc_m = rst_n ? (in_tvalid & tready_s) : '0;
        end
    end

    // Output monitor: a beat seen with valid&&ready at the falling edge is consumed next edge.
    initial begin
        logic [DW:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && o_v && out_tready) begin
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected_beat got=%h", {o_l, o_d});
                end else begin
                    e = sb_q.pop_front();
                    if ({o_l, o_d} !== e) begin
                        failures++;
                        $display("FAIL sb_beat got=%h exp=%h", {o_l, o_d}, e);
                    end
                end
                n_pops++;
            end
        end
    end

    task automatic hold_reset();
        rst_n = 1'b0;
        for (int i = 0; i < NP; i++) port_q[i].delete();
        sb_q.delete();
        out_tready = 1'b1;
        cnt_clear  = 1'b0;
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic do_reset();
        hold_reset();
        release_reset();
    endtask

    task automatic wait_drain(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            #1;
            if (sb_q.size() == 0 && !o_v) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        hold_reset();
        #1;
        checks++;
        if (tready0 !== '0 || tready1 !== '0) begin
            failures++;
            $display("FAIL reset_tready got=%b/%b exp=0", tready0, tready1);
        end
        release_reset();
        @(negedge clk);
        checks++;
        if (v0 !== 1'b0 || d0 !== '0 || l0 !== 1'b0 || v1 !== 1'b0) begin
            failures++;
            $display("FAIL reset_out got v=%b d=%h l=%b exp=0", v0, d0, l0);
        end
        checks++;
        if (pc0 !== '0 || st0 !== '0 || pc1 !== '0 || st1 !== '0) begin
            failures++;
            $display("FAIL reset_counters got pc0=%h st0=%h pc1=%h st1=%h exp=0", pc0, st0, pc1, st1);
        end
    endtask

    task automatic test_single_packet();
        bit ok;
        sel = 1'b0;
        do_reset();
        src_pkt(2, 0, 3);
        exp_pkt(2, 0, 3);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (in_tvalid[2] && tready0[2]) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin failures++; $display("FAIL t1_accept got=timeout exp=accept"); end
        checks++;
        if (tready0 !== 5'b00100) begin
            failures++;
            $display("FAIL t1_tready got=%b exp=00100", tready0);
        end
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            checks++;
            if (v0 !== 1'b1 || d0 !== mk(2, 0, b) || l0 !== (b == 2)) begin
                failures++;
                $display("FAIL t1_beat%0d got v=%b d=%h l=%b exp d=%h", b, v0, d0, l0, mk(2, 0, b));
            end
        end
        wait_drain(ok);
        checks++;
        if (!ok || pc0 !== {16'd0, 16'd0, 16'd1, 16'd0, 16'd0}) begin
            failures++;
            $display("FAIL t1_pkt_count got=%h drained=%0d exp port2=1", pc0, ok);
        end
    endtask

    task automatic test_round_robin();
        bit ok, cont;
        sel = 1'b0;
        do_reset();
        for (int p = 0; p < NP; p++) begin
            src_pkt(p, 0, 2);
            exp_pkt(p, 0, 2);
        end
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (v0) begin ok = 1'b1; break; end
        end
        cont = ok;
        for (int b = 1; b < 10; b++) begin
            @(negedge clk);
            if (v0 !== 1'b1) cont = 1'b0;
        end
        checks++;
        if (!cont) begin failures++; $display("FAIL t2_rr_continuous got=gap exp=10 beats in 10 cycles"); end
        @(negedge clk);
        checks++;
        if (v0 !== 1'b0) begin failures++; $display("FAIL t2_rr_extra got v=%b exp=0", v0); end
        wait_drain(ok);
        checks++;
        if (!ok || pc0 !== {5{16'd1}}) begin
            failures++;
            $display("FAIL t2_rr_counts got=%h drained=%0d exp all 1", pc0, ok);
        end
    endtask

    task automatic test_fixed_priority();
        bit ok, cont;
        sel = 1'b1;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            src_pkt(0, k, 2);
            exp_pkt(0, k, 2);
        end
        for (int p = 1; p < NP; p++) begin
            src_pkt(p, 0, 2);
            exp_pkt(p, 0, 2);
        end
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (v1) begin ok = 1'b1; break; end
        end
        cont = ok;
        for (int b = 1; b < 14; b++) begin
            @(negedge clk);
            if (v1 !== 1'b1) cont = 1'b0;
        end
        checks++;
        if (!cont) begin failures++; $display("FAIL t2_fixed_continuous got=gap exp=14 beats"); end
        wait_drain(ok);
        checks++;
        if (!ok || pc1 !== {2'd1, 2'd1, 2'd1, 2'd1, 2'd3}) begin
            failures++;
            $display("FAIL t2_fixed_counts got=%b drained=%0d exp=0101010111", pc1, ok);
        end
        sel = 1'b0;
    endtask

    task automatic test_lock();
        bit ok, bad;
        int a1;
        sel = 1'b0;
        do_reset();
        a1 = acc_cnt[1];
        exp_pkt(1, 0, 4);
        exp_pkt(0, 0, 1);
        port_q[1].push_back({1'b0, mk(1, 0, 0)});
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (acc_cnt[1] >= a1 + 1) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin failures++; $display("FAIL t3_first_beat got=timeout exp=accept"); end
        src_pkt(0, 0, 1);
        repeat (3) @(negedge clk);
        checks++;
        if (tready0 !== 5'b00010 || v0 !== 1'b0) begin
            failures++;
            $display("FAIL t3_bubble got tready=%b v=%b exp tready=00010 v=0", tready0, v0);
        end
        for (int b = 1; b < 4; b++) port_q[1].push_back({(b == 3), mk(1, 0, b)});
        ok  = 1'b0;
        bad = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (acc_cnt[1] >= a1 + 4) begin ok = 1'b1; break; end
            if (tready0[0] !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (!ok || bad) begin
            failures++;
            $display("FAIL t3_lock got done=%0d leak=%0d exp done=1 leak=0", ok, bad);
        end
        checks++;
        if (tready0 !== 5'b00001) begin
            failures++;
            $display("FAIL t3_next_grant got=%b exp=00001", tready0);
        end
        wait_drain(ok);
        checks++;
        if (!ok || pc0 !== {16'd0, 16'd0, 16'd0, 16'd1, 16'd1}) begin
            failures++;
            $display("FAIL t3_counts got=%h drained=%0d exp ports0,1=1", pc0, ok);
        end
    endtask

    task automatic test_backpressure();
        bit ok, stable;
        int p0;
        sel = 1'b0;
        do_reset();
        p0 = n_pops;
        src_pkt(3, 0, 4);
        exp_pkt(3, 0, 4);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            #1;
            if (n_pops == p0 + 1) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin failures++; $display("FAIL t4_start got=timeout exp=first beat"); end
        @(posedge clk);
        #1;
        out_tready = 1'b0;
        stable = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (v0 !== 1'b1 || d0 !== mk(3, 0, 1) || l0 !== 1'b0) stable = 1'b0;
        end
        checks++;
        if (!stable) begin
            failures++;
            $display("FAIL t4_hold got v=%b d=%h exp d=%h", v0, d0, mk(3, 0, 1));
        end
        @(posedge clk);
        #1;
        out_tready = 1'b1;
        wait_drain(ok);
        checks++;
        if (!ok || st0 !== 16'd4) begin
            failures++;
            $display("FAIL t4_stall_count got=%0d drained=%0d exp=4", st0, ok);
        end
        checks++;
        if (n_pops - p0 != 4 || pc0[3*CW0 +: CW0] !== 16'd1) begin
            failures++;
            $display("FAIL t4_beats got=%0d pkts=%0d exp=4 beats 1 pkt", n_pops - p0, pc0[3*CW0 +: CW0]);
        end
    endtask

    task automatic test_saturation();
        bit ok;
        sel = 1'b1;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            src_pkt(3, k, 1);
            exp_pkt(3, k, 1);
        end
        wait_drain(ok);
        checks++;
        if (!ok || pc1[3*CW1 +: CW1] !== 2'd3) begin
            failures++;
            $display("FAIL t5_saturate got=%0d drained=%0d exp=3", pc1[3*CW1 +: CW1], ok);
        end
        src_pkt(3, 5, 1);
        exp_pkt(3, 5, 1);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (in_tvalid[3] && tready1[3] && in_tlast[3]) begin
                cnt_clear = 1'b1;
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        cnt_clear = 1'b0;
        checks++;
        if (!ok || pc1 !== '0) begin
            failures++;
            $display("FAIL t5_clear_wins got=%b found=%0d exp=0", pc1, ok);
        end
        wait_drain(ok);
        src_pkt(3, 6, 1);
        exp_pkt(3, 6, 1);
        wait_drain(ok);
        checks++;
        if (!ok || pc1[3*CW1 +: CW1] !== 2'd1) begin
            failures++;
            $display("FAIL t5_after_clear got=%0d drained=%0d exp=1", pc1[3*CW1 +: CW1], ok);
        end
        sel = 1'b0;
    endtask

    task automatic test_reset_mid_packet();
        bit ok;
        int p0;
        sel = 1'b0;
        do_reset();
        src_pkt(1, 0, 1);
        exp_pkt(1, 0, 1);
        wait_drain(ok);
        checks++;
        if (!ok || pc0[1*CW0 +: CW0] !== 16'd1) begin
            failures++;
            $display("FAIL t6_pre_count got=%0d exp=1", pc0[1*CW0 +: CW0]);
        end
        p0 = n_pops;
        src_pkt(4, 1, 4);
        exp_pkt(4, 1, 4);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            #1;
            if (n_pops == p0 + 2) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin failures++; $display("FAIL t6_mid_packet got=timeout exp=2 beats"); end
        hold_reset();
        #1;
        checks++;
        if (v0 !== 1'b0 || l0 !== 1'b0 || d0 !== '0) begin
            failures++;
            $display("FAIL t6_async_clear got v=%b d=%h l=%b exp=0", v0, d0, l0);
        end
        checks++;
        if (pc0 !== '0 || st0 !== '0 || tready0 !== '0) begin
            failures++;
            $display("FAIL t6_counters got pc=%h st=%h tready=%b exp=0", pc0, st0, tready0);
        end
        release_reset();
        src_pkt(4, 2, 1);
        src_pkt(0, 2, 1);
        exp_pkt(0, 2, 1);
        exp_pkt(4, 2, 1);
        wait_drain(ok);
        checks++;
        if (!ok || pc0 !== {16'd1, 16'd0, 16'd0, 16'd0, 16'd1}) begin
            failures++;
            $display("FAIL t6_restart got=%h drained=%0d exp ports0,4=1", pc0, ok);
        end
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_round_robin();
        test_fixed_priority();
        test_lock();
        test_backpressure();
        test_saturation();
        test_reset_mid_packet();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
